// File: rtl/rv_timer_if.sv
// rv_timer bus interface.
// Byte-addressed register port with a registered read return.
interface rv_timer_if;
  logic [4:0]  adr;
  logic        cs;
  logic        rdy;
  logic [3:0]  we;
  logic        re;
  logic [31:0] dw;
  logic [31:0] dr;

  modport master (
    output adr, cs, rdy, we, re, dw,
    input  dr
  );

  modport slave (
    input  adr, cs, rdy, we, re, dw,
    output dr
  );
endinterface

// File: rtl/rv_timer.sv
// rv_timer: prescaled 32-bit counter with compare match,
// overflow flag and level interrupt on a small register bus.
module rv_timer #(
  parameter int unsigned PRESC_W  = 16,
  parameter logic [31:0] CMP_INIT = 32'hFFFF_FFFF
) (
  input  logic      clk,
  input  logic      xreset,
  rv_timer_if.slave bus,
  output logic      irq
);

  logic               acc;
  logic               wr;
  logic               rd;
  logic [2:0]         a;

  logic               sel_ctrl;
  logic               sel_presc;
  logic               sel_count;
  logic               sel_cmp;
  logic               sel_stat;

  logic [3:0]         ctrl_q;
  logic [3:0]         ctrl_d;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;
  logic [PRESC_W-1:0] pcnt_q;
  logic [PRESC_W-1:0] pcnt_d;
  logic [31:0]        count_q;
  logic [31:0]        count_d;
  logic [31:0]        cmp_q;
  logic [31:0]        cmp_d;
  logic               match_q;
  logic               match_d;
  logic               ovf_q;
  logic               ovf_d;
  logic [31:0]        dr_q;
  logic [31:0]        dr_d;
  logic               irq_q;
  logic               irq_d;

  logic               en;
  logic               tick;
  logic               set_m;
  logic               set_o;
  logic               clr;
  logic [31:0]        rdat;
  logic [31:0]        wval;
  logic               unused;

  assign acc = bus.cs & bus.rdy;
  assign wr  = acc & (|bus.we);
  assign rd  = acc & bus.re;
  assign a   = bus.adr[4:2];

  assign sel_ctrl  = (a == 3'd0);
  assign sel_presc = (a == 3'd1);
  assign sel_count = (a == 3'd2);
  assign sel_cmp   = (a == 3'd3);
  assign sel_stat  = (a == 3'd4);

  assign unused = ^{bus.adr[1:0]};

  always_comb begin
    rdat = '0;
    unique case (1'b1)
      sel_ctrl:  rdat = {28'd0, ctrl_q};
      sel_presc: rdat = {{(32-PRESC_W){1'b0}}, presc_q};
      sel_count: rdat = count_q;
      sel_cmp:   rdat = cmp_q;
      sel_stat:  rdat = {30'd0, ovf_q, match_q};
      default:   rdat = '0;
    endcase
  end

  // Unwritten lanes keep the addressed register's current bytes.
  always_comb begin
    wval = rdat;
    for (int i = 0; i < 4; i++) begin
      if (bus.we[i]) begin
        wval[8*i +: 8] = bus.dw[8*i +: 8];
      end
    end
  end

  assign en   = ctrl_q[0];
  assign tick = en & (pcnt_q == presc_q);

  always_comb begin
    pcnt_d = pcnt_q + PRESC_W'(1);
    if (!en || tick || (wr && sel_presc)) begin
      pcnt_d = '0;
    end
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    cmp_d   = cmp_q;
    if (wr && sel_ctrl) begin
      ctrl_d = wval[3:0];
    end
    if (wr && sel_presc) begin
      presc_d = wval[PRESC_W-1:0];
    end
    if (wr && sel_cmp) begin
      cmp_d = wval;
    end
  end

  // A bus write to COUNT overrides the tick and its flag effects.
  always_comb begin
    count_d = count_q;
    set_m   = 1'b0;
    set_o   = 1'b0;
    if (wr && sel_count) begin
      count_d = wval;
    end else if (tick) begin
      if (count_q == cmp_q) begin
        set_m = 1'b1;
        if (ctrl_q[2]) begin
          count_d = '0;
        end else begin
          count_d = count_q + 32'd1;
          set_o   = &count_q;
        end
      end else begin
        count_d = count_q + 32'd1;
        set_o   = &count_q;
      end
    end
  end

  assign clr = wr & sel_stat & bus.we[0];

  always_comb begin
    match_d = match_q;
    ovf_d   = ovf_q;
    if (clr && bus.dw[0]) begin
      match_d = 1'b0;
    end
    if (clr && bus.dw[1]) begin
      ovf_d = 1'b0;
    end
    if (set_m) begin
      match_d = 1'b1;
    end
    if (set_o) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    dr_d  = dr_q;
    irq_d = (match_q & ctrl_q[1]) | (ovf_q & ctrl_q[3]);
    if (rd) begin
      dr_d = rdat;
    end
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      count_q <= '0;
      cmp_q   <= CMP_INIT;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      dr_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
      dr_q    <= dr_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.dr = dr_q;
  assign irq    = irq_q;

endmodule
